serial_display_driver: RTL and testbench

//  Parametrised serial output engine for the desk-clock display chain: accepts a full display frame
//  (NUM_DIGITS x DIGIT_BITS segment bits) via valid/ready and shifts it into external 74HC595-style

---
 rtl/serial_display_driver.sv | 168 ++++++++++++++++
 tb/tb_serial_display_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_display_driver.sv
// Shifts a captured display frame into 74HC595-style chains, then latches; 2*HALF_DIV*(BPC+LATCH_CYCLES) cycles per frame, ready only when idle and enabled.
// Optional SERIAL_DISPLAY_BRIGHTNESS_EN adds a 4-bit PWM on o_serial_oe_n; otherwise it is held low after reset.
module serial_display_driver #(
    parameter int SYS_CLK_HZ   = 5_000_000,
    parameter int SHIFT_CLK_HZ = 1_000_000,
    parameter int NUM_DIGITS   = 6,
    parameter int DIGIT_BITS   = 8,
    parameter int NUM_CHAINS   = 1,
    parameter int LATCH_CYCLES = 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_en,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] i_frame,
    input  logic                             i_frame_valid,
    output logic                             o_frame_ready,
    input  logic                             i_msb_first,
    input  logic [3:0]                       i_brightness,
    output logic [NUM_CHAINS-1:0]            o_serial_data,
    output logic                             o_serial_clk,
    output logic                             o_serial_latch,
    output logic                             o_serial_oe_n
);
    localparam int FRAME_BITS = NUM_DIGITS * DIGIT_BITS;
    localparam int BPC        = FRAME_BITS / NUM_CHAINS;
    localparam int HALF_RAW   = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
    localparam int HALF_DIV   = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int LATCH_LEN  = 2 * HALF_DIV * LATCH_CYCLES;
    localparam int HALF_W     = $clog2(HALF_DIV + 1);
    localparam int BIT_W      = $clog2(BPC + 1);
    localparam int LAT_W      = $clog2(LATCH_LEN + 1);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BPC - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATCH_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;
    typedef logic [NUM_CHAINS-1:0][BPC-1:0] slices_t;

    state_t                r_state, w_state_nx;
    logic [HALF_W-1:0]     r_half, w_half_nx;
    logic [BIT_W-1:0]      r_bit, w_bit_nx;
    logic [LAT_W-1:0]      r_lat, w_lat_nx;
    slices_t               r_shreg, w_shreg_nx, w_slices;
    logic                  r_msb, w_msb_nx;
    logic [NUM_CHAINS-1:0] r_data, w_data_nx;
    logic                  r_sclk, w_sclk_nx;
    logic                  r_latch, w_latch_nx;
    logic                  r_ready, w_ready_nx;
    logic                  r_oe_n;

    assign w_slices = i_frame;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_half  <= '0;
            r_bit   <= '0;
            r_lat   <= '0;
            r_shreg <= '0;
            r_msb   <= 1'b0;
            r_data  <= '0;
            r_sclk  <= 1'b0;
            r_latch <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_half  <= w_half_nx;
            r_bit   <= w_bit_nx;
            r_lat   <= w_lat_nx;
            r_shreg <= w_shreg_nx;
            r_msb   <= w_msb_nx;
            r_data  <= w_data_nx;
            r_sclk  <= w_sclk_nx;
            r_latch <= w_latch_nx;
            r_ready <= w_ready_nx;
        end
    end

    // The shift register is pre-advanced so its end bit is always the next bit to present.
    always_comb begin
        w_state_nx = r_state;
        w_half_nx  = r_half;
        w_bit_nx   = r_bit;
        w_lat_nx   = r_lat;
        w_shreg_nx = r_shreg;
        w_msb_nx   = r_msb;
        w_data_nx  = r_data;
        w_sclk_nx  = r_sclk;
        w_latch_nx = r_latch;
        case (r_state)
            S_IDLE: begin
                if (i_frame_valid && r_ready) begin
                    w_state_nx = S_SHIFT;
                    w_half_nx  = '0;
                    w_bit_nx   = '0;
                    w_msb_nx   = i_msb_first;
                    w_sclk_nx  = 1'b0;
                    for (int c = 0; c < NUM_CHAINS; c++) begin
                        w_data_nx[c]  = i_msb_first ? w_slices[c][BPC-1] : w_slices[c][0];
                        w_shreg_nx[c] = i_msb_first ? (w_slices[c] << 1) : (w_slices[c] >> 1);
                    end
                end
            end
            S_SHIFT: begin
                if (r_half != HALF_LAST) begin
                    w_half_nx = r_half + HALF_W'(1);
                end else begin
                    w_half_nx = '0;
                    if (!r_sclk) begin
                        w_sclk_nx = 1'b1;
                    end else if (r_bit == BIT_LAST) begin
                        w_state_nx = S_LATCH;
                        w_sclk_nx  = 1'b0;
                        w_data_nx  = '0;
                        w_latch_nx = 1'b1;
                        w_lat_nx   = '0;
                    end else begin
                        w_bit_nx  = r_bit + BIT_W'(1);
                        w_sclk_nx = 1'b0;
                        for (int c = 0; c < NUM_CHAINS; c++) begin
                            w_data_nx[c]  = r_msb ? r_shreg[c][BPC-1] : r_shreg[c][0];
                            w_shreg_nx[c] = r_msb ? (r_shreg[c] << 1) : (r_shreg[c] >> 1);
                        end
                    end
                end
            end
            S_LATCH: begin
                if (r_lat != LAT_LAST) begin
                    w_lat_nx = r_lat + LAT_W'(1);
                end else begin
                    w_state_nx = S_IDLE;
                    w_latch_nx = 1'b0;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        w_ready_nx = (w_state_nx == S_IDLE) && i_en;
    end

`ifdef SERIAL_DISPLAY_BRIGHTNESS_EN
    logic [3:0] r_pwm;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pwm  <= '0;
            r_oe_n <= 1'b1;
        end else begin
            r_pwm  <= r_pwm + 4'd1;
            r_oe_n <= ~(r_pwm < i_brightness);
        end
    end
`else
    logic w_unused_brightness;
    assign w_unused_brightness = ^i_brightness;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_oe_n <= 1'b1;
        else         r_oe_n <= 1'b0;
    end
`endif

    assign o_frame_ready  = r_ready;
    assign o_serial_data  = r_data;
    assign o_serial_clk   = r_sclk;
    assign o_serial_latch = r_latch;
    assign o_serial_oe_n  = r_oe_n;
endmodule

// File: tb/tb_serial_display_driver.sv
// Directed bench for serial_display_driver: one-chain and two-chain instances, defaults otherwise.
module tb_serial_display_driver;
    logic        clk = 1'b0;
    logic        rst, en, msb, v1, v2;
    logic [47:0] frame;
    logic [3:0]  bright;
    logic [0:0]  d1;
    logic        c1, l1, r1, oe1;
    logic [1:0]  d2;
    logic        c2, l2, r2, oe2;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    serial_display_driver dut1 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_frame(frame), .i_frame_valid(v1),
        .o_frame_ready(r1), .i_msb_first(msb), .i_brightness(bright),
        .o_serial_data(d1), .o_serial_clk(c1), .o_serial_latch(l1), .o_serial_oe_n(oe1)
    );

    serial_display_driver #(.NUM_CHAINS(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_frame(frame), .i_frame_valid(v2),
        .o_frame_ready(r2), .i_msb_first(msb), .i_brightness(bright),
        .o_serial_data(d2), .o_serial_clk(c2), .o_serial_latch(l2), .o_serial_oe_n(oe2)
    );

    typedef struct {
        logic [47:0] frame;
        logic        msb;
        logic [47:0] exp1;
        logic [23:0] exp_c0;
        logic [23:0] exp_c1;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data1"}, 64'(d1), 64'h0);
        chk({tag, "_clk1"}, 64'(c1), 64'h0);
        chk({tag, "_latch1"}, 64'(l1), 64'h0);
        chk({tag, "_ready1"}, 64'(r1), 64'h0);
        chk({tag, "_oe_n1"}, 64'(oe1), 64'h1);
        chk({tag, "_data2"}, 64'(d2), 64'h0);
        chk({tag, "_oe_n2"}, 64'(oe2), 64'h1);
    endtask

    // Offer one frame to the selected instance and record what a 595 chain would see.
    task automatic run_frame(input int which, input logic [47:0] f, input logic m,
                             input int en_drop_at, input int stop_at,
                             output logic [47:0] acc0, output logic [47:0] acc1,
                             output int edges, output int lat, output int rdy_at,
                             output int latch_bad);
        logic pclk, cclk, cd0, cd1, clat, crdy;
        int   w;
        acc0 = '0; acc1 = '0; edges = 0; lat = 0; rdy_at = -1; latch_bad = 0;
        w = 0;
        while (((which == 0) ? r1 : r2) !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (((which == 0) ? r1 : r2) !== 1'b1) begin
            chk("ready_wait", 64'h0, 64'h1);
            rdy_at = -2;
            return;
        end
        frame = f; msb = m;
        if (which == 0) v1 = 1'b1; else v2 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0; frame = ~f; msb = ~m;
        pclk = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (which == 0) begin
                cclk = c1; cd0 = d1[0]; cd1 = 1'b0; clat = l1; crdy = r1;
            end else begin
                cclk = c2; cd0 = d2[0]; cd1 = d2[1]; clat = l2; crdy = r2;
            end
            if (cclk && !pclk) begin
                acc0 = {acc0[46:0], cd0};
                acc1 = {acc1[46:0], cd1};
                edges++;
                if (edges == en_drop_at) en = 1'b0;
                if (edges == stop_at) return;
            end
            if (clat) begin
                lat++;
                if (cd0 || cd1 || cclk) latch_bad++;
            end
            if (crdy) begin
                rdy_at = k;
                break;
            end
            pclk = cclk;
        end
    endtask

    logic [47:0] a0, a1;
    int          ed, lt, ra, lb;
    int          caps, pulses, start, stop, low_cnt;
    logic        pre, pc, pl;

    initial begin
        vecs[0] = '{48'hA5_00_FF_01_80_3C, 1'b1, 48'hA5_00_FF_01_80_3C, 24'h01803C, 24'hA500FF};
        vecs[1] = '{48'hA5_00_FF_01_80_3C, 1'b0, 48'h3C_01_80_FF_00_A5, 24'h3C0180, 24'hFF00A5};
        vecs[2] = '{48'h12_34_56_78_9A_BC, 1'b0, 48'h3D_59_1E_6A_2C_48, 24'h3D591E, 24'h6A2C48};
        vecs[3] = '{48'h12_34_56_78_9A_BC, 1'b1, 48'h12_34_56_78_9A_BC, 24'h789ABC, 24'h123456};

        rst = 1'b1; en = 1'b1; msb = 1'b0; v1 = 1'b0; v2 = 1'b0; frame = '0; bright = 4'd4;
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready1_after_reset", 64'(r1), 64'h1);
        chk("ready2_after_reset", 64'(r2), 64'h1);

        for (int i = 0; i < 4; i++) begin
            run_frame(0, vecs[i].frame, vecs[i].msb, -1, -1, a0, a1, ed, lt, ra, lb);
            chk($sformatf("v%0d_stream1", i), 64'(a0), 64'(vecs[i].exp1));
            chk($sformatf("v%0d_edges1", i), 64'(ed), 64'd48);
            chk($sformatf("v%0d_latch1", i), 64'(lt), 64'd4);
            chk($sformatf("v%0d_ready_at1", i), 64'(ra), 64'd196);
            chk($sformatf("v%0d_latch_idle1", i), 64'(lb), 64'd0);
            run_frame(1, vecs[i].frame, vecs[i].msb, -1, -1, a0, a1, ed, lt, ra, lb);
            chk($sformatf("v%0d_chain0", i), 64'(a0), {40'h0, vecs[i].exp_c0});
            chk($sformatf("v%0d_chain1", i), 64'(a1), {40'h0, vecs[i].exp_c1});
            chk($sformatf("v%0d_edges2", i), 64'(ed), 64'd24);
            chk($sformatf("v%0d_latch2", i), 64'(lt), 64'd4);
            chk($sformatf("v%0d_ready_at2", i), 64'(ra), 64'd100);
        end

        // Reset in the middle of bit 20: everything drops at once, no latch ever seen.
        run_frame(0, vecs[0].frame, 1'b1, -1, 20, a0, a1, ed, lt, ra, lb);
        chk("rst_mid_edges", 64'(ed), 64'd20);
        chk("rst_mid_no_latch", 64'(lt), 64'd0);
        #2 rst = 1'b1;
        #1 chk_reset("rst_mid");
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_latch", 64'(l1), 64'h0);
        chk("rst_hold_clk", 64'(c1), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 64'(r1), 64'h1);
        run_frame(0, vecs[0].frame, 1'b1, -1, -1, a0, a1, ed, lt, ra, lb);
        chk("post_rst_stream", 64'(a0), 64'(vecs[0].exp1));
        chk("post_rst_latch", 64'(lt), 64'd4);
        chk("post_rst_ready_at", 64'(ra), 64'd196);

        // Enable dropped at bit 10: frame finishes, ready waits for enable.
        run_frame(0, vecs[1].frame, 1'b0, 10, -1, a0, a1, ed, lt, ra, lb);
        chk("en_drop_stream", 64'(a0), 64'(vecs[1].exp1));
        chk("en_drop_edges", 64'(ed), 64'd48);
        chk("en_drop_latch", 64'(lt), 64'd4);
        chk("en_drop_no_ready", 64'(ra), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("en_drop_ready_low", 64'(r1), 64'h0);
        en = 1'b1;
        @(negedge clk);
        chk("en_restore_ready", 64'(r1), 64'h1);

        // Valid held continuously for three frames.
        frame = vecs[0].frame; msb = 1'b1; v1 = 1'b1;
        pre = r1; caps = 0; ed = 0; pulses = 0; pc = 1'b0; pl = 1'b0; start = -1; stop = -1;
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            if (pre && v1) begin
                caps++;
                if (caps == 1) start = k;
                if (caps == 3) #1 v1 = 1'b0;
            end
            @(negedge clk);
            if (c1 && !pc) ed++;
            if (l1 && !pl) pulses++;
            pc = c1; pl = l1; pre = r1;
            if (caps == 3 && r1) begin
                stop = k;
                break;
            end
        end
        v1 = 1'b0;
        chk("b2b_latch_pulses", 64'(pulses), 64'd3);
        chk("b2b_edges", 64'(ed), 64'd144);
        chk("b2b_span", 64'(stop - start), 64'd590);

`ifdef SERIAL_DISPLAY_BRIGHTNESS_EN
        low_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!oe1) low_cnt++;
        end
        chk("pwm_4_low_cycles", 64'(low_cnt), 64'd4);
        bright = 4'd0;
        repeat (2) @(negedge clk);
        low_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!oe1) low_cnt++;
        end
        chk("pwm_0_low_cycles", 64'(low_cnt), 64'd0);
`else
        low_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (!oe1 && !oe2) low_cnt++;
        end
        chk("oe_always_on", 64'(low_cnt), 64'd32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
